// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Counter width for a counter that runs 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer with 3-sample majority vote around mid-bit.
// decide strobes at t_count==H+1 (majority valid that cycle); wrap strobes at the last count of the bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BAUDGEN_PERIOD = 1600
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic rx_sync,
  output logic bit_val,
  output logic decide,
  output logic wrap
);

  localparam int TW = cnt_width(BAUDGEN_PERIOD);
  localparam int H  = BAUDGEN_PERIOD / 2;
  localparam logic [TW-1:0] T_S0   = TW'(H - 1);
  localparam logic [TW-1:0] T_S1   = TW'(H);
  localparam logic [TW-1:0] T_DEC  = TW'(H + 1);
  localparam logic [TW-1:0] T_LAST = TW'(BAUDGEN_PERIOD - 1);

  logic [TW-1:0] t_count;
  logic          s0;
  logic          s1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      t_count <= '0;
    end else if (t_count == T_LAST) begin
      t_count <= '0;
    end else begin
      t_count <= t_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (t_count == T_S0) s0 <= rx_sync;
      if (t_count == T_S1) s1 <= rx_sync;
    end
  end

  // Third sample is the live line at the decision cycle itself.
  assign bit_val = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
  assign decide  = !clear && (t_count == T_DEC);
  assign wrap    = !clear && (t_count == T_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, optional parity, 1-2 stop bits, break detect, held output word.
// valid rises one clock after the last stop decision; while valid&!ready a new frame is dropped with a 1-cycle overrun.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int NUM_SYNC_STAGE = 5,
  parameter int BAUDGEN_PERIOD = 1600,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 ready,
  output logic                 valid,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 p_error,
  output logic                 f_error,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam int               BW        = cnt_width(DATA_BITS);
  localparam logic [BW-1:0]    LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam parity_e          PMODE     = parity_e'(PARITY);

  logic [NUM_SYNC_STAGE-1:0] sync;
  logic                      rx_sync;
  rx_state_e                 state;
  rx_state_e                 state_next;
  logic                      bit_val;
  logic                      decide;
  logic                      wrap;
  logic [BW-1:0]             bit_cnt;
  logic                      stop_cnt;
  logic [DATA_BITS-1:0]      sh;
  logic                      par_bit;
  logic                      f_acc;
  logic                      brk_cand;
  logic                      frame_done;
  logic                      frame_brk;
  logic                      perr;
  logic                      load;

  always_ff @(posedge clk) begin
    if (reset) sync <= '1;
    else       sync <= {sync[NUM_SYNC_STAGE-2:0], rx_in};
  end
  assign rx_sync = sync[NUM_SYNC_STAGE-1];

  uart_bit_timer #(
    .BAUDGEN_PERIOD(BAUDGEN_PERIOD)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ST_IDLE),
    .rx_sync (rx_sync),
    .bit_val (bit_val),
    .decide  (decide),
    .wrap    (wrap)
  );

  // A break is only recognised on the first stop bit, with every earlier bit low.
  assign brk_cand = (stop_cnt == 1'b0) && !bit_val && (sh == '0) &&
                    ((PMODE == PARITY_NONE) || !par_bit);
  assign perr     = (PMODE != PARITY_NONE) &&
                    ((^sh ^ par_bit) != (PMODE == PARITY_ODD));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    frame_brk  = 1'b0;
    case (state)
      ST_IDLE:   if (!rx_sync) state_next = ST_START;
      ST_START: begin
        if (decide && bit_val) state_next = ST_IDLE;
        else if (wrap)         state_next = ST_DATA;
      end
      ST_DATA: begin
        if (wrap && (bit_cnt == LAST_BIT))
          state_next = (PMODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (wrap) state_next = ST_STOP;
      ST_STOP: begin
        if (decide) begin
          if (brk_cand) begin
            frame_done = 1'b1;
            frame_brk  = 1'b1;
            state_next = ST_BREAK;
          end else if (stop_cnt == LAST_STOP) begin
            frame_done = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_BREAK:  if (rx_sync) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      sh       <= '0;
      par_bit  <= 1'b0;
      f_acc    <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        f_acc    <= 1'b0;
      end
      if (state == ST_DATA && decide)             sh       <= {bit_val, sh[DATA_BITS-1:1]};
      if (state == ST_DATA && wrap)               bit_cnt  <= bit_cnt + 1'b1;
      if (state == ST_PARITY && decide)           par_bit  <= bit_val;
      if (state == ST_STOP && decide && !bit_val) f_acc    <= 1'b1;
      if (state == ST_STOP && wrap)               stop_cnt <= stop_cnt + 1'b1;
    end
  end

  assign load = frame_done && (!valid || ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= 1'b0;
      d_out     <= '0;
      p_error   <= 1'b0;
      f_error   <= 1'b0;
      break_det <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= frame_done && valid && !ready;
      if (load) begin
        valid     <= 1'b1;
        d_out     <= frame_brk ? '0 : sh;
        p_error   <= !frame_brk && perr;
        f_error   <= frame_brk || f_acc || !bit_val;
        break_det <= frame_brk;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed and randomized frames on three receiver configurations, checked against a frame-level model.
module tb_uart_rx_cfg;

  localparam int P   = 16;
  localparam int NS  = 2;
  localparam int H   = P / 2;
  // line edge -> sync -> START -> start+8 data bits -> stop decision -> valid
  localparam int LAT = NS + 1 + P * 9 + (H + 1) + 1;

  typedef struct {
    int d;
    int p;
    int f;
    int b;
    int cyc;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rx;
  logic [2:0] rdy;
  logic [2:0] vld;
  logic [2:0] pe;
  logic [2:0] fe;
  logic [2:0] bk;
  logic [2:0] ov;
  logic [2:0] bz;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int ovr_cnt  = 0;
  obs_t q0[$];
  obs_t q1[$];
  obs_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.NUM_SYNC_STAGE(NS), .BAUDGEN_PERIOD(P), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .rx_in(rx[0]), .ready(rdy[0]), .valid(vld[0]), .d_out(d0),
    .p_error(pe[0]), .f_error(fe[0]), .break_det(bk[0]), .overrun(ov[0]), .busy(bz[0]));

  uart_rx_cfg #(.NUM_SYNC_STAGE(NS), .BAUDGEN_PERIOD(P), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .reset(reset), .rx_in(rx[1]), .ready(rdy[1]), .valid(vld[1]), .d_out(d1),
    .p_error(pe[1]), .f_error(fe[1]), .break_det(bk[1]), .overrun(ov[1]), .busy(bz[1]));

  uart_rx_cfg #(.NUM_SYNC_STAGE(NS), .BAUDGEN_PERIOD(P), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .reset(reset), .rx_in(rx[2]), .ready(rdy[2]), .valid(vld[2]), .d_out(d2),
    .p_error(pe[2]), .f_error(fe[2]), .break_det(bk[2]), .overrun(ov[2]), .busy(bz[2]));

  function automatic obs_t mk(input int d, input int p, input int f, input int b, input int c);
    obs_t o;
    o.d = d; o.p = p; o.f = f; o.b = b; o.cyc = c;
    return o;
  endfunction

  // Every accepted word (valid & ready), as seen away from the active edge.
  always @(negedge clk) begin
    if (vld[0] && rdy[0]) q0.push_back(mk(int'(d0), int'(pe[0]), int'(fe[0]), int'(bk[0]), cyc));
    if (vld[1] && rdy[1]) q1.push_back(mk(int'(d1), int'(pe[1]), int'(fe[1]), int'(bk[1]), cyc));
    if (vld[2] && rdy[2]) q2.push_back(mk(int'(d2), int'(pe[2]), int'(fe[2]), int'(bk[2]), cyc));
    if (bz[0]) busy_cnt++;
    if (ov[0]) ovr_cnt++;
  end

  // Frame-level reference: what the word and flags should be for the bits put on the line.
  function automatic obs_t model(input int nbits, input int data, input int pmode, input int pbit,
                                 input int s0, input int s1, input int nstop);
    obs_t o;
    int dm;
    int ones;
    dm = data & ((1 << nbits) - 1);
    o  = mk(dm, 0, 0, 0, 0);
    if (dm == 0 && (pmode == 0 || pbit == 0) && s0 == 0) begin
      o.d = 0; o.f = 1; o.b = 1;
    end else begin
      ones = $countones(dm) + pbit;
      if (pmode != 0) o.p = ((ones % 2) != ((pmode == 1) ? 1 : 0)) ? 1 : 0;
      o.f = (s0 == 0 || (nstop == 2 && s1 == 0)) ? 1 : 0;
    end
    return o;
  endfunction

  function automatic int qlen(input int ln);
    case (ln)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic obs_t qpop(input int ln);
    case (ln)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic drive_bit(input int ln, input int v, input int n);
    rx[ln] = (v != 0);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int ln, input int nbits, input int data, input int pmode, input int pbit,
                            input int s0, input int s1, input int nstop, input int idle_bits);
    drive_bit(ln, 0, P);
    for (int i = 0; i < nbits; i++) drive_bit(ln, (data >> i) & 1, P);
    if (pmode != 0) drive_bit(ln, pbit, P);
    drive_bit(ln, s0, P);
    if (nstop == 2) drive_bit(ln, s1, P);
    drive_bit(ln, 1, idle_bits * P);
  endtask

  task automatic check_next(input int ln, input obs_t want, input string tag, output obs_t got);
    int waited;
    waited = 0;
    got = mk(-1, -1, -1, -1, -1);
    while (qlen(ln) == 0 && waited < 40 * P) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    assert (qlen(ln) > 0) else begin
      failures++;
      $error("FAIL %s_arrival got=none want=one word", tag);
    end
    if (qlen(ln) > 0) begin
      got = qpop(ln);
      chk({tag, "_d"}, got.d, want.d);
      chk({tag, "_perr"}, got.p, want.p);
      chk({tag, "_ferr"}, got.f, want.f);
      chk({tag, "_brk"}, got.b, want.b);
    end
  endtask

  initial begin
    obs_t got;
    obs_t exp_q[$];
    int   c0;
    int   b0;
    int   o0;
    int   n0;
    int   d;
    int   pb;
    int   s1;

    reset = 1'b1;
    rx    = '1;
    rdy   = '1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", int'(vld), 0);
    chk("rst_dout", int'(d0), 0);
    chk("rst_perr", int'(pe[0]), 0);
    chk("rst_ferr", int'(fe[0]), 0);
    chk("rst_brk", int'(bk[0]), 0);
    chk("rst_ovr", int'(ov[0]), 0);
    chk("rst_busy", int'(bz), 0);
    repeat (2 * P) @(negedge clk);

    // 8N1 0xA5 with latency and single-word checks
    c0 = cyc;
    send_frame(0, 8, 'hA5, 0, 0, 1, 1, 1, 2);
    check_next(0, model(8, 'hA5, 0, 0, 1, 1, 1), "a5", got);
    chk("a5_latency", got.cyc - c0, LAT);
    chk("a5_single", qlen(0), 0);

    // 7E1 0x41, wrong then right parity bit
    send_frame(1, 7, 'h41, 2, 1, 1, 1, 1, 2);
    check_next(1, model(7, 'h41, 2, 1, 1, 1, 1), "e41_bad", got);
    send_frame(1, 7, 'h41, 2, 0, 1, 1, 1, 2);
    check_next(1, model(7, 'h41, 2, 0, 1, 1, 1), "e41_ok", got);

    // 8N2 0x3C with second stop bit low
    send_frame(2, 8, 'h3C, 0, 0, 1, 0, 2, 2);
    check_next(2, model(8, 'h3C, 0, 0, 1, 0, 2), "n2_3c", got);

    // short low glitch is a false start
    b0 = busy_cnt;
    n0 = qlen(0);
    drive_bit(0, 0, 5);
    drive_bit(0, 1, 3 * P);
    chk("glitch_busy_len", busy_cnt - b0, H + 2);
    chk("glitch_busy_end", int'(bz[0]), 0);
    chk("glitch_no_valid", qlen(0), n0);

    // break, then a normal frame once the line is high again
    drive_bit(0, 0, 12 * P);
    drive_bit(0, 1, 2 * P);
    check_next(0, model(8, 0, 0, 0, 0, 0, 1), "break", got);
    chk("break_single", qlen(0), 0);
    send_frame(0, 8, 'h55, 0, 0, 1, 1, 1, 2);
    check_next(0, model(8, 'h55, 0, 0, 1, 1, 1), "after_brk", got);

    // back-to-back random 8N1 frames with no idle time
    for (int i = 0; i < 6; i++) begin
      d = int'($urandom_range(0, 255));
      exp_q.push_back(model(8, d, 0, 0, 1, 1, 1));
      send_frame(0, 8, d, 0, 0, 1, 1, 1, 0);
    end
    drive_bit(0, 1, 2 * P);
    for (int i = 0; i < 6; i++) check_next(0, exp_q[i], "b2b", got);
    chk("b2b_count", qlen(0), 0);

    // random 7E1 frames with random parity bit
    for (int i = 0; i < 8; i++) begin
      d  = int'($urandom_range(0, 127));
      pb = int'($urandom_range(0, 1));
      send_frame(1, 7, d, 2, pb, 1, 1, 1, 1);
      check_next(1, model(7, d, 2, pb, 1, 1, 1), "e1_rand", got);
    end

    // random 8N2 frames with random second stop bit
    for (int i = 0; i < 8; i++) begin
      d  = int'($urandom_range(1, 255));
      s1 = int'($urandom_range(0, 1));
      send_frame(2, 8, d, 0, 0, 1, s1, 2, 1);
      check_next(2, model(8, d, 0, 0, 1, s1, 2), "n2_rand", got);
    end

    // consumer stalled: second frame overruns, first word held
    rdy[0] = 1'b0;
    send_frame(0, 8, 'h11, 0, 0, 1, 1, 1, 2);
    chk("hold_valid", int'(vld[0]), 1);
    chk("hold_d", int'(d0), 'h11);
    o0 = ovr_cnt;
    send_frame(0, 8, 'h22, 0, 0, 1, 1, 1, 2);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    chk("ovr_d_kept", int'(d0), 'h11);
    chk("ovr_valid_kept", int'(vld[0]), 1);
    @(posedge clk);
    #1 rdy[0] = 1'b1;
    @(negedge clk);
    chk("accept_valid_still", int'(vld[0]), 1);
    @(posedge clk);
    #1 chk("accept_valid_drop", int'(vld[0]), 0);
    check_next(0, model(8, 'h11, 0, 0, 1, 1, 1), "accepted", got);

    // reset in the middle of a frame
    @(negedge clk);
    n0 = qlen(0);
    drive_bit(0, 0, P);
    drive_bit(0, 1, P);
    drive_bit(0, 0, 2 * P);
    reset = 1'b1;
    rx[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12 * P) @(negedge clk);
    chk("midrst_no_valid", qlen(0), n0);
    chk("midrst_valid", int'(vld[0]), 0);
    chk("midrst_d", int'(d0), 0);
    chk("midrst_flags", int'({pe[0], fe[0], bk[0], ov[0]}), 0);
    chk("midrst_busy", int'(bz[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
